ov_capture: RTL and testbench

- Camera pixel-capture stage between the OV2640 parallel bus and the dual-port frame buffer's write port.
- Runs in the camera pixel-clock domain.
- Packs RGB565 byte pairs into 12-bit RGB444 words and generates linear write addresses for a 640x480 frame.
- Discards the first frames after reset while sensor registers settle, and clamps every write to the frame bounds.

---
 rtl/ov_pkg.sv | 31 +++
 rtl/ov_byte_pack.sv | 44 ++++
 rtl/ov_capture.sv | 144 ++++++++++++++
 tb/tb_ov_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov_pkg.sv
// Shared constants for the OV2640 capture path and the VGA reader:
// frame geometry, pixel width, capture states and RGB565 field positions.
package ov_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int RGB444_W     = 12;

   typedef enum logic [1:0] {
      ST_SKIP    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } cap_state_t;

   // High byte carries R[4:0],G[5:3]; low byte carries G[2:0],B[4:0].
   localparam int HI_R_MSB = 7;   // R[4]
   localparam int HI_R_LSB = 4;   // R[1]
   localparam int HI_G_MSB = 2;   // G[5]
   localparam int HI_G_LSB = 0;   // G[3]
   localparam int LO_G_BIT = 7;   // G[2]
   localparam int LO_B_MSB = 4;   // B[4]
   localparam int LO_B_LSB = 1;   // B[1]

   // Keep the top four bits of each RGB565 channel: {R[4:1], G[5:2], B[4:1]}.
   function automatic logic [RGB444_W-1:0] pack_565_to_444(input logic [7:0] hi,
                                                           input logic [7:0] lo);
      return {hi[HI_R_MSB:HI_R_LSB], hi[HI_G_MSB:HI_G_LSB], lo[LO_G_BIT],
              lo[LO_B_MSB:LO_B_LSB]};
   endfunction

endpackage

// File: rtl/ov_byte_pack.sv
// Pairs camera bytes into RGB444 pixels. Inputs are the already-registered
// bus copies. pixel_valid is a one-cycle pulse; pixels that complete while
// VSYNC is high are discarded.
module ov_byte_pack
   import ov_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                href,
   input  logic                vsync,
   input  logic [7:0]          data,
   output logic                pixel_valid,
   output logic [RGB444_W-1:0] pixel
);

   logic       phase;
   logic [7:0] hi_byte;

   // Toggle the byte phase while HREF is high; phase 0 latches the high byte,
   // phase 1 emits the packed pixel. HREF low restarts at phase 0, so an odd
   // trailing byte is simply forgotten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= 1'b0;
         hi_byte     <= 8'h00;
         pixel_valid <= 1'b0;
         pixel       <= '0;
      end else begin
         pixel_valid <= 1'b0;
         if (!href) begin
            phase <= 1'b0;
         end else begin
            phase <= ~phase;
            if (!phase) begin
               hi_byte <= data;
            end else begin
               pixel       <= pack_565_to_444(hi_byte, data);
               pixel_valid <= ~vsync;
            end
         end
      end
   end

endmodule

// File: rtl/ov_capture.sv
// OV2640 capture stage: registers the camera bus, skips the first frames
// after reset, then writes RGB444 pixels to linear frame-buffer addresses,
// clamped to H_ACTIVE x V_ACTIVE.
module ov_capture
   import ov_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int SKIP_FRAMES = 2,
   parameter int ADDR_W      = 19
)(
   input  logic                PCLK_OV,
   input  logic                rst,
   input  logic                VSYNC_OV,
   input  logic                HREF_OV,
   input  logic [7:0]          OV_Data_in,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   w_addr,
   output logic [RGB444_W-1:0] w_data,
   output logic                frame_done,
   output logic                short_frame,
   output cap_state_t          state_dbg
);

   localparam int COL_W  = $clog2(H_ACTIVE + 1);
   localparam int LINE_W = $clog2(V_ACTIVE + 1);
   localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
   localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_ACTIVE);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
   localparam logic [3:0]        SKIP_N    = 4'(SKIP_FRAMES);

   logic                vsync_r, vsync_d, href_r, href_d;
   logic [7:0]          data_r;
   logic                vsync_rise, href_fall;
   logic                pixel_valid;
   logic [RGB444_W-1:0] pixel;

   cap_state_t          state;
   logic [3:0]          skip_cnt;
   logic [COL_W-1:0]    column, col_after;
   logic [LINE_W-1:0]   line_cnt;
   logic [ADDR_W-1:0]   line_base;
   logic                store_pix;

   // Register the camera bus once, plus a second delay for edge detection.
   always_ff @(posedge PCLK_OV or negedge rst) begin
      if (!rst) begin
         vsync_r <= 1'b0;
         vsync_d <= 1'b0;
         href_r  <= 1'b0;
         href_d  <= 1'b0;
         data_r  <= 8'h00;
      end else begin
         vsync_r <= VSYNC_OV;
         vsync_d <= vsync_r;
         href_r  <= HREF_OV;
         href_d  <= href_r;
         data_r  <= OV_Data_in;
      end
   end

   assign vsync_rise = vsync_r & ~vsync_d;
   assign href_fall  = ~href_r & href_d;

   ov_byte_pack u_pack (
      .clk        (PCLK_OV),
      .rst_n      (rst),
      .href       (href_r),
      .vsync      (vsync_r),
      .data       (data_r),
      .pixel_valid(pixel_valid),
      .pixel      (pixel)
   );

   // A pixel is stored only while capturing and inside the frame bounds.
   assign store_pix = (state == ST_CAPTURE) && pixel_valid &&
                      (column < COL_MAX) && (line_cnt < LINE_MAX);
   assign col_after = column + COL_W'(store_pix);
   assign state_dbg = state;

   // Frame FSM, address counters and the registered write port.
   always_ff @(posedge PCLK_OV or negedge rst) begin
      if (!rst) begin
         state       <= ST_SKIP;
         skip_cnt    <= 4'd0;
         column      <= '0;
         line_cnt    <= '0;
         line_base   <= '0;
         wr_en       <= 1'b0;
         w_addr      <= '0;
         w_data      <= '0;
         frame_done  <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         if (store_pix) begin
            wr_en  <= 1'b1;
            w_addr <= line_base + ADDR_W'(column);
            w_data <= pixel;
         end
         case (state)
            ST_SKIP: begin
               if (SKIP_N == 4'd0) begin
                  state <= ST_ARMED;
               end else if (vsync_rise) begin
                  skip_cnt <= skip_cnt + 4'd1;
                  if (skip_cnt + 4'd1 == SKIP_N) state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (vsync_rise) begin
                  state     <= ST_CAPTURE;
                  column    <= '0;
                  line_cnt  <= '0;
                  line_base <= '0;
               end
            end
            ST_CAPTURE: begin
               if (vsync_rise) begin
                  frame_done <= 1'b1;
                  if (line_cnt < LINE_MAX) short_frame <= 1'b1;
                  column    <= '0;
                  line_cnt  <= '0;
                  line_base <= '0;
               end else if (href_fall) begin
                  // The last pixel of a line can land on the same edge as
                  // the HREF fall, so judge the line on col_after.
                  column <= '0;
                  if (col_after != '0) begin
                     line_cnt <= line_cnt + 1'b1;
                     if (line_cnt < LINE_LAST) line_base <= line_base + LINE_STEP;
                  end
               end else begin
                  column <= col_after;
               end
            end
            default: state <= ST_SKIP;
         endcase
      end
   end

endmodule

// File: tb/tb_ov_capture.sv
// Randomised bench for ov_capture with a line/frame level reference model
// and an ordered expected-event queue checked by an independent monitor.
module tb_ov_capture;
   import ov_pkg::*;

   localparam int H    = 8;
   localparam int V    = 6;
   localparam int SKIP = 2;
   localparam int AW   = 6;
   localparam int EW   = 2 + AW + RGB444_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic vsync = 1'b0;
   logic href = 1'b0;
   logic [7:0] din = 8'h00;

   logic                wr_en;
   logic [AW-1:0]       w_addr;
   logic [RGB444_W-1:0] w_data;
   logic                frame_done;
   logic                short_frame;
   cap_state_t          state_dbg;

   ov_capture #(
      .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP), .ADDR_W(AW)
   ) dut (
      .PCLK_OV    (clk),
      .rst        (rst),
      .VSYNC_OV   (vsync),
      .HREF_OV    (href),
      .OV_Data_in (din),
      .wr_en      (wr_en),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .frame_done (frame_done),
      .short_frame(short_frame),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [EW-1:0] exp_q[$];
   int            exp_t_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   int vs_seen      = 0;
   bit capturing    = 1'b0;
   int stored_lines = 0;
   int col          = 0;
   bit sticky       = 1'b0;

   function automatic logic [11:0] ref_pixel(input int hi, input int lo);
      int r5, g6, b5;
      r5 = hi / 8;
      g6 = (hi % 8) * 8 + lo / 32;
      b5 = lo % 32;
      return 12'((r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2));
   endfunction

   task automatic model_pixel(input int hi, input int lo);
      if (capturing && stored_lines < V && col < H) begin
         exp_q.push_back({1'b0, 1'b0, AW'(stored_lines * H + col), ref_pixel(hi, lo)});
         exp_t_q.push_back(cyc + 3);
         col++;
      end
   endtask

   task automatic model_vsync_rise();
      vs_seen++;
      if (capturing) begin
         if (stored_lines < V) sticky = 1'b1;
         exp_q.push_back({1'b1, sticky, AW'(0), 12'h000});
         exp_t_q.push_back(cyc + 2);
      end
      capturing    = (vs_seen >= SKIP + 1);
      stored_lines = 0;
      col          = 0;
   endtask

   // ---------------- driver tasks ----------------
   logic [7:0] line_bytes[$];

   task automatic fill_random(input int n);
      line_bytes.delete();
      repeat (n) line_bytes.push_back(8'($urandom_range(0, 255)));
   endtask

   // Drives one HREF line; optionally raises VSYNC together with the last byte.
   task automatic send_line(input bit vs_on_last);
      int hi = 0;
      foreach (line_bytes[i]) begin
         @(negedge clk);
         href = 1'b1;
         din  = line_bytes[i];
         if (vs_on_last && i == line_bytes.size() - 1) begin
            vsync = 1'b1;
            model_vsync_rise();
         end else if (i % 2 == 1) begin
            model_pixel(hi, int'(line_bytes[i]));
         end else begin
            hi = int'(line_bytes[i]);
         end
      end
      @(negedge clk);
      href = 1'b0;
      if (col > 0) stored_lines++;
      col = 0;
      if (vs_on_last) begin
         repeat (2) @(negedge clk);
         vsync = 1'b0;
      end
      repeat ($urandom_range(2, 5)) @(negedge clk);
   endtask

   task automatic send_frame(input int n_lines, input int n_bytes);
      repeat (n_lines) begin
         fill_random(n_bytes);
         send_line(1'b0);
      end
   endtask

   task automatic vsync_pulse(input bit href_during);
      @(negedge clk);
      vsync = 1'b1;
      model_vsync_rise();
      if (href_during) begin
         @(negedge clk);
         repeat (4) begin
            @(negedge clk);
            href = 1'b1;
            din  = 8'($urandom_range(0, 255));
         end
         @(negedge clk);
         href = 1'b0;
      end
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " wr_en"}, 32'(wr_en), 0);
      check({tag, " w_addr"}, 32'(w_addr), 0);
      check({tag, " w_data"}, 32'(w_data), 0);
      check({tag, " frame_done"}, 32'(frame_done), 0);
      check({tag, " short_frame"}, 32'(short_frame), 0);
      check({tag, " state"}, 32'(state_dbg), 32'(ST_SKIP));
   endtask

   // ---------------- monitor ----------------
   bit prev_wr = 1'b0;
   bit prev_fd = 1'b0;

   task automatic check_event(input bit is_fd);
      logic [EW-1:0] e;
      int t;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected %s: got addr 0x%0h data 0x%0h, expected no event (cycle %0d)",
                  is_fd ? "frame_done" : "write", w_addr, w_data, cyc);
         return;
      end
      e = exp_q.pop_front();
      t = exp_t_q.pop_front();
      check("event kind", 32'(is_fd), 32'(e[EW-1]));
      check("event cycle", cyc, t);
      if (is_fd) begin
         check("short_frame at frame end", 32'(short_frame), 32'(e[EW-2]));
      end else begin
         check("w_addr", 32'(w_addr), 32'(e[AW+11:12]));
         check("w_data", 32'(w_data), 32'(e[11:0]));
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (wr_en) begin
            check("wr_en back-to-back", 32'(prev_wr), 0);
            check_event(1'b0);
         end
         if (frame_done) begin
            check("frame_done width", 32'(prev_fd), 0);
            check_event(1'b1);
         end
         prev_wr = wr_en;
         prev_fd = frame_done;
      end else begin
         prev_wr = 1'b0;
         prev_fd = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Two skipped frames, one armed frame, then capture.
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      check("state after third VSYNC", 32'(state_dbg), 32'(ST_CAPTURE));

      // Pure red, green, blue then random pixels on line 0; full frame.
      line_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
      repeat (2 * H - 6) line_bytes.push_back(8'($urandom_range(0, 255)));
      send_line(1'b0);
      send_frame(V - 1, 2 * H);
      vsync_pulse(1'b0);
      check("short_frame after full frame", 32'(short_frame), 32'(sticky));

      // Overlong line with an odd byte, an empty HREF pulse, surplus lines.
      fill_random(2 * (H + 2) + 1);  send_line(1'b0);
      fill_random(1);                send_line(1'b0);
      send_frame(V + 1, 2 * H);
      vsync_pulse(1'b0);

      // Short frame with random line lengths.
      repeat (3) begin
         fill_random($urandom_range(2, 2 * H + 5));
         send_line(1'b0);
      end
      vsync_pulse(1'b0);
      check("short_frame sticky", 32'(short_frame), 32'(sticky));

      // HREF activity while VSYNC is high must not write.
      send_frame(2, 2 * H);
      vsync_pulse(1'b1);

      // VSYNC rises together with a second byte; next frame restarts at 0.
      send_frame(1, 2 * H);
      fill_random(6);
      send_line(1'b1);
      send_frame(2, 2 * H);
      vsync_pulse(1'b0);

      // Asynchronous reset in the middle of a captured line.
      fill_random(2 * H);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         href = 1'b1;
         din  = line_bytes[i];
         if (i % 2 == 1) model_pixel(int'(line_bytes[i-1]), int'(line_bytes[i]));
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_idle_outputs("async reset");
      exp_q.delete();
      exp_t_q.delete();
      vs_seen      = 0;
      capturing    = 1'b0;
      stored_lines = 0;
      col          = 0;
      sticky       = 1'b0;
      href         = 1'b0;
      din          = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Skip frames are counted again after reset.
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      send_frame(V, 2 * H);  vsync_pulse(1'b0);
      check("short_frame cleared by reset", 32'(short_frame), 32'(sticky));

      repeat (10) @(negedge clk);
      check("expected events drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
